// File: rtl/sisc_ctrl_if.sv
// Control bus between the SISC instruction/status registers and the multi-cycle control FSM.
// The master side presents the decoded instruction fields; the slave side drives the datapath controls.
interface sisc_ctrl_if;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       pc_rst;
    logic       pc_write;
    logic       pc_sel;
    logic       br_sel;
    logic       ir_load;
    logic       rf_we;
    logic       wb_sel;
    logic [1:0] alu_op;
    logic       stat_en;
    logic       dm_we;
    logic       halted;

    modport master (
        output opcode, mm, stat,
        input  pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, wb_sel,
               alu_op, stat_en, dm_we, halted
    );

    modport slave (
        input  opcode, mm, stat,
        output pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, wb_sel,
               alu_op, stat_en, dm_we, halted
    );
endinterface

// File: rtl/sisc_ctrl.sv
// Multi-cycle control FSM for the SISC core: START/FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT.
// Optional macro CTRL_FAST_RETIRE_EN: NOP/undefined/branch instructions retire straight from DECODE.
module sisc_ctrl #(
    parameter int unsigned START_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_f,
    sisc_ctrl_if.slave    ctrl
);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_e;

    localparam logic [3:0] OP_ALU = 4'b0001;
    localparam logic [3:0] OP_BRA = 4'b0010;
    localparam logic [3:0] OP_BRR = 4'b0011;
    localparam logic [3:0] OP_BNE = 4'b0100;
    localparam logic [3:0] OP_BNR = 4'b0101;
    localparam logic [3:0] OP_LOD = 4'b1000;
    localparam logic [3:0] OP_STR = 4'b1100;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_MODE = 2'b01;
    localparam logic [1:0] ALU_ADDR = 2'b10;

    localparam logic [3:0] START_LAST = 4'(START_CYCLES - 1);

`ifdef CTRL_FAST_RETIRE_EN
    localparam logic FAST_RETIRE = 1'b1;
`else
    localparam logic FAST_RETIRE = 1'b0;
`endif

    state_e     state_q;
    logic [3:0] start_cnt_q;
    logic [3:0] opc_s;

    assign opc_s = ctrl.opcode;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BRA) || (op == OP_BRR) || (op == OP_BNE) || (op == OP_BNR);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOD) || (op == OP_STR);
    endfunction

    // Condition c is any masked flag set; BRA/BRR treat an empty mask as "always".
    function automatic logic branch_taken(input logic [3:0] op,
                                          input logic [3:0] mask,
                                          input logic [3:0] flags);
        logic c;
        c = |(mask & flags);
        case (op)
            OP_BRA, OP_BRR: return (mask == 4'd0) || c;
            OP_BNE, OP_BNR: return (mask != 4'd0) && !c;
            default:        return 1'b0;
        endcase
    endfunction

    // Instructions with no execute/memory/writeback work may skip straight back to FETCH.
    function automatic logic retires_early(input logic [3:0] op);
        return FAST_RETIRE && !((op == OP_ALU) || is_mem_op(op) || (op == OP_HLT));
    endfunction

    // State register and START dwell counter.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q     <= ST_START;
            start_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                ST_START: begin
                    if (start_cnt_q >= START_LAST) begin
                        state_q     <= ST_FETCH;
                        start_cnt_q <= 4'd0;
                    end else begin
                        start_cnt_q <= start_cnt_q + 4'd1;
                    end
                end
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    if (opc_s == OP_HLT) begin
                        state_q <= ST_HALT;
                    end else if (retires_early(opc_s)) begin
                        state_q <= ST_FETCH;
                    end else begin
                        state_q <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (is_mem_op(opc_s)) begin
                        state_q <= ST_MEM;
                    end else begin
                        state_q <= ST_WRITEBACK;
                    end
                end
                ST_MEM: begin
                    if (opc_s == OP_LOD) begin
                        state_q <= ST_WRITEBACK;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_WRITEBACK: state_q <= ST_FETCH;
                ST_HALT:      state_q <= ST_HALT;
                default: begin
                    state_q     <= ST_START;
                    start_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    // Datapath controls decoded from the current state and the IR opcode.
    always_comb begin
        ctrl.pc_rst   = 1'b0;
        ctrl.pc_write = 1'b0;
        ctrl.pc_sel   = 1'b0;
        ctrl.br_sel   = 1'b0;
        ctrl.ir_load  = 1'b0;
        ctrl.rf_we    = 1'b0;
        ctrl.wb_sel   = 1'b0;
        ctrl.alu_op   = ALU_PASS;
        ctrl.stat_en  = 1'b0;
        ctrl.dm_we    = 1'b0;
        ctrl.halted   = 1'b0;
        case (state_q)
            ST_START: ctrl.pc_rst = 1'b1;
            ST_FETCH: begin
                ctrl.ir_load  = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            ST_DECODE: begin
                if (is_branch(opc_s)) begin
                    ctrl.br_sel   = (opc_s == OP_BRR) || (opc_s == OP_BNR);
                    ctrl.pc_write = branch_taken(opc_s, ctrl.mm, ctrl.stat);
                    ctrl.pc_sel   = branch_taken(opc_s, ctrl.mm, ctrl.stat);
                end else begin
                    ctrl.br_sel   = 1'b0;
                end
            end
            ST_EXECUTE: begin
                case (opc_s)
                    OP_ALU: begin
                        ctrl.alu_op  = ALU_MODE;
                        ctrl.stat_en = 1'b1;
                    end
                    OP_LOD, OP_STR: ctrl.alu_op = ALU_ADDR;
                    default:        ctrl.alu_op = ALU_PASS;
                endcase
            end
            ST_MEM: begin
                case (opc_s)
                    OP_STR: begin
                        ctrl.alu_op = ALU_ADDR;
                        ctrl.dm_we  = 1'b1;
                    end
                    OP_LOD:  ctrl.alu_op = ALU_ADDR;
                    default: ctrl.alu_op = ALU_PASS;
                endcase
            end
            ST_WRITEBACK: begin
                case (opc_s)
                    OP_ALU: begin
                        ctrl.alu_op = ALU_MODE;
                        ctrl.rf_we  = 1'b1;
                    end
                    OP_LOD: begin
                        ctrl.alu_op = ALU_ADDR;
                        ctrl.rf_we  = 1'b1;
                        ctrl.wb_sel = 1'b1;
                    end
                    default: ctrl.rf_we = 1'b0;
                endcase
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ctrl.pc_rst = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Randomized bench for sisc_ctrl: an instruction-level model expands each instruction into
// its expected per-cycle control vector sequence, compared cycle by cycle against the DUT.
module tb_sisc_ctrl;
    localparam int START_CYCLES = 2;

    logic clk;
    logic rst_f;
    int   n_tests;
    int   n_fail;

    sisc_ctrl_if ifc ();

    sisc_ctrl #(.START_CYCLES(START_CYCLES)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .ctrl  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {pc_rst,pc_write,pc_sel,br_sel,ir_load,rf_we,wb_sel,alu_op[1:0],stat_en,dm_we,halted}
    logic [11:0] obs;
    assign obs = {ifc.pc_rst, ifc.pc_write, ifc.pc_sel, ifc.br_sel, ifc.ir_load, ifc.rf_we,
                  ifc.wb_sel, ifc.alu_op, ifc.stat_en, ifc.dm_we, ifc.halted};

    function automatic logic [11:0] vec(input bit pcr, input bit pcw, input bit pcs, input bit brs,
                                        input bit irl, input bit rfw, input bit wbs,
                                        input bit [1:0] alu, input bit se, input bit dmw,
                                        input bit hlt);
        return {pcr, pcw, pcs, brs, irl, rfw, wbs, alu, se, dmw, hlt};
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: list of control vectors an instruction produces, one per cycle.
    task automatic expect_seq(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] st,
                              output logic [11:0] q[$]);
        bit is_br, rel, taken, heavy;
        q.delete();
        q.push_back(vec(0, 1, 0, 0, 1, 0, 0, 2'd0, 0, 0, 0));
        is_br = (op >= 4'd2) && (op <= 4'd5);
        rel   = (op == 4'd3) || (op == 4'd5);
        if (op == 4'd2 || op == 4'd3) taken = (mm == 4'd0) || ((mm & st) != 4'd0);
        else if (op == 4'd4 || op == 4'd5) taken = (mm != 4'd0) && ((mm & st) == 4'd0);
        else taken = 1'b0;
        q.push_back(vec(0, taken, taken, is_br && rel, 0, 0, 0, 2'd0, 0, 0, 0));
        if (op == 4'd15) return;
        heavy = (op == 4'd1) || (op == 4'd8) || (op == 4'd12);
`ifdef CTRL_FAST_RETIRE_EN
        if (!heavy) return;
`endif
        if (op == 4'd1)                     q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 2'd1, 1, 0, 0));
        else if (op == 4'd8 || op == 4'd12) q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 0));
        else                                q.push_back(12'd0);
        if (op == 4'd12) begin
            q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 1, 0));
            return;
        end
        if (op == 4'd8) q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 0));
        if (op == 4'd1)      q.push_back(vec(0, 0, 0, 0, 0, 1, 0, 2'd1, 0, 0, 0));
        else if (op == 4'd8) q.push_back(vec(0, 0, 0, 0, 0, 1, 1, 2'd2, 0, 0, 0));
        else                 q.push_back(12'd0);
        if (heavy && op == 4'd1) n_tests = n_tests; // keeps heavy meaningful in both builds
    endtask

    // Hold reset for n_low edges then release; START must show pc_rst for START_CYCLES cycles.
    task automatic reset_seq(input int n_low);
        logic [11:0] v_start;
        v_start = vec(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
        rst_f = 1'b0;
        for (int i = 0; i < n_low; i++) begin
            @(posedge clk); #1;
            chk_val($sformatf("reset_low%0d", i), obs, v_start);
        end
        rst_f = 1'b1;
        for (int i = 0; i < START_CYCLES; i++) begin
            #1;
            chk_val($sformatf("start%0d", i), obs, v_start);
            @(posedge clk); #1;
        end
    endtask

    // Run one instruction from its FETCH cycle; optional reset at cycle rst_at, HLT holds for hold cycles.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] st,
                             input int rst_at, input int hold);
        logic [11:0] q[$];
        expect_seq(op, mm, st, q);
        if (op == 4'd15) begin
            for (int i = 0; i < hold; i++) q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1));
        end
        ifc.opcode = op;
        ifc.mm     = mm;
        ifc.stat   = st;
        for (int i = 0; i < q.size(); i++) begin
            if (i == rst_at) rst_f = 1'b0;
            #1;
            chk_val($sformatf("op%b_mm%b_st%b_cyc%0d", op, mm, st, i), obs, q[i]);
            @(posedge clk); #1;
            if (i == rst_at) begin
                chk_val("reset_abort_start", obs, vec(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
                reset_seq(1);
                return;
            end
        end
        if (op == 4'd15) reset_seq(2);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_f       = 1'b0;
        ifc.opcode  = 4'd0;
        ifc.mm      = 4'd0;
        ifc.stat    = 4'd0;
        reset_seq(3);
        run_instr(4'b0001, 4'b0000, 4'b0000, -1, 0);
        run_instr(4'b0011, 4'b0001, 4'b0001, -1, 0);
        run_instr(4'b0011, 4'b0001, 4'b0000, -1, 0);
        run_instr(4'b0100, 4'b0100, 4'b0100, -1, 0);
        run_instr(4'b0100, 4'b0100, 4'b0000, -1, 0);
        run_instr(4'b0010, 4'b0000, 4'b1010, -1, 0);
        run_instr(4'b0101, 4'b0000, 4'b0000, -1, 0);
        run_instr(4'b1000, 4'b0011, 4'b0000, -1, 0);
        run_instr(4'b1100, 4'b0011, 4'b0000, -1, 0);
        run_instr(4'b0000, 4'b0000, 4'b0000, -1, 0);
        run_instr(4'b1111, 4'b0000, 4'b0000, -1, 20);
        run_instr(4'b0001, 4'b0101, 4'b0000, 2, 0);
        for (int n = 0; n < 400; n++) begin
            logic [3:0] op, mm, st;
            int         rst_at;
            op     = 4'($urandom_range(0, 15));
            mm     = 4'($urandom_range(0, 15));
            st     = 4'($urandom_range(0, 15));
            rst_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_instr(op, mm, st, rst_at, int'($urandom_range(1, 25)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sisc_ctrl.md
Name: sisc_ctrl

Overview:
- Multi-cycle control FSM for the SISC core; the stage directly upstream of the program counter.
- Sequences fetch / decode / execute / memory / writeback for each instruction.
- Drives pc_rst, pc_write and pc_sel into the PC, plus IR load, register-file, ALU, branch-unit and data-memory controls.
- Evaluates the branch condition from the latched status flags.

Parameters:
- START_CYCLES, 2: cycles spent in START after reset release, with pc_rst=1 held; legal range 1..15.

Ports:
- clk  input  1  system clock, posedge active
- rst_f  input  1  reset; synchronous, active-low
- opcode  input  4  instr[31:28] from the instruction register
- mm  input  4  instr[27:24]; branch mask (C,N,V,Z) or ALU/memory mode
- stat  input  4  latched status flags {C,N,V,Z}
- pc_rst  output  1  PC reset request
- pc_write  output  1  PC load enable
- pc_sel  output  1  0 = PC+1, 1 = branch address
- br_sel  output  1  0 = absolute branch, 1 = relative branch (PC + imm)
- ir_load  output  1  instruction register load
- rf_we  output  1  register-file write enable
- wb_sel  output  1  0 = ALU result, 1 = data-memory read data
- alu_op  output  2  00 = pass, 01 = arithmetic/logic per mm, 10 = address add, 11 = reserved
- stat_en  output  1  status register update enable
- dm_we  output  1  data-memory write enable
- halted  output  1  high while in HALT

Behaviour:
- States: START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT; state register is 3 bits.
- Reset: rst_f=0 sampled at posedge moves to START and clears the START counter. Reset mid-instruction aborts it; no rf_we or dm_we is issued afterwards.
- Outputs are combinational from state and opcode. Every output is 0 unless listed for the current state.
- Output values while rst_f=0 and in START: pc_rst=1, all others 0.
- START: stays START_CYCLES cycles, then goes to FETCH.
- FETCH: ir_load=1, pc_write=1, pc_sel=0. The PC advances to PC+1 at the same edge the IR loads. Next state DECODE.
- DECODE: evaluates the branch condition; c = |(mm & stat).
  - BRA (0010) / BRR (0011): taken if mm==0 or c==1.
  - BNE (0100) / BNR (0101): taken if mm!=0 and c==0.
  - br_sel=1 for BRR/BNR, 0 for BRA/BNE, driven in DECODE for all branch opcodes.
  - If taken: pc_sel=1 and pc_write=1 in DECODE, so the PC loads the branch address at the DECODE edge.
  - HLT (1111): next state HALT.
  - Otherwise: next state EXECUTE.
- EXECUTE:
  - ALU (0001): alu_op=01, stat_en=1.
  - LOD (1000) / STR (1100): alu_op=10, stat_en=0.
  - Others: all controls 0.
  - LOD/STR go to MEM; all other opcodes go to WRITEBACK.
- MEM:
  - STR: alu_op=10, dm_we=1, then next state FETCH.
  - LOD: alu_op=10, then next state WRITEBACK.
- WRITEBACK:
  - ALU: alu_op=01, rf_we=1, wb_sel=0.
  - LOD: alu_op=10, rf_we=1, wb_sel=1.
  - Others: no writes.
  - Next state FETCH.
- Undefined opcodes are treated as NOP: DECODE -> EXECUTE -> WRITEBACK -> FETCH with no writes.
- HALT: halted=1; stays in HALT until rst_f=0. pc_write=0 and no other writes.
- Latency:
  - ALU, NOP and branches: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - LOD: 5 cycles.
  - STR: 4 cycles (FETCH, DECODE, EXECUTE, MEM).
- Simultaneous events: rst_f=0 overrides every transition, including HALT. pc_rst and pc_write are never both 1.

Optional Feature:
- Macro CTRL_FAST_RETIRE_EN.
- Defined: NOP, undefined opcodes, and any branch (taken or not) go DECODE -> FETCH directly. These instructions take 2 cycles; ALU, LOD, STR and HLT are unchanged.
- Undefined: the 4-cycle path described above.

Test Plan:
- rst_f=0 for 3 cycles, then 1 (START_CYCLES=2) -> pc_rst=1 through reset and 2 further cycles; first FETCH in the 3rd cycle after release with ir_load=1, pc_write=1, pc_sel=0.
- ALU opcode=0001, mm=0 -> EXECUTE: alu_op=01, stat_en=1; WRITEBACK: rf_we=1, wb_sel=0; FETCH follows 4 cycles after the previous FETCH.
- BRR mm=0001, stat=0001 -> DECODE: pc_sel=1, pc_write=1, br_sel=1. With stat=0000 -> pc_write=0 in DECODE.
- BNE mm=0100, stat=0100 -> not taken. With stat=0000 -> taken, br_sel=0.
- LOD then STR -> LOD: MEM then WRITEBACK, rf_we=1, wb_sel=1, 5 cycles. STR: dm_we=1 in MEM only, rf_we never 1, 4 cycles.
- HLT, then hold 20 cycles, then rst_f=0 during EXECUTE of a subsequent ALU instruction:
  - HLT: halted=1 and pc_write=0 for all 20 cycles.
  - Reset: START next cycle, rf_we never asserted.
  - With CTRL_FAST_RETIRE_EN defined, NOP takes 2 cycles between FETCHes.
